// File: rtl/data_memory_pkg.sv
// Shared types for the data-memory store path: store widths, the store
// buffer entry as seen on the pop/packet interface, and the drain FSM states.
package data_memory_pkg;

   // Access size of a committed store.
   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } store_width_t;

   // One committed store as delivered by the store buffer after a pop.
   typedef struct packed {
      logic [31:0]  address;
      logic [31:0]  data;
      store_width_t store_width;
   } store_buffer_entry_t;

   // Drain sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      POP   = 2'd1,
      LATCH = 2'd2,
      WRITE = 2'd3
   } drain_state_t;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   // Word address of the containing 32-bit location.
   function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
      return {addr[DATA_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/store_lane_aligner.sv
// Maps a store's width and low address bits onto the 32-bit data bus:
// active byte lanes, lane-replicated data and a misalignment flag.
module store_lane_aligner
   import data_memory_pkg::*;
(
   input  logic [1:0]        addr_lsb_i,
   input  store_width_t      width_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [BE_W-1:0]   be_o,
   output logic [DATA_W-1:0] lane_data_o,
   output logic              misaligned_o
);

   // Lane selection and replication per access size.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      be_o         = '0;
      lane_data_o  = '0;
      misaligned_o = 1'b0;
      case (width_i)
         BYTE: begin
            be_o        = 4'b0001 << addr_lsb_i;
            lane_data_o = {4{data_i[7:0]}};
         end
         HALF: begin
            be_o         = addr_lsb_i[1] ? 4'b1100 : 4'b0011;
            lane_data_o  = {2{data_i[15:0]}};
            misaligned_o = addr_lsb_i[0];
         end
         WORD: begin
            be_o         = 4'b1111;
            lane_data_o  = data_i;
            misaligned_o = (addr_lsb_i != 2'b00);
         end
         // An undefined width code cannot be written safely; drop it like a
         // misaligned entry.
         default: misaligned_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/store_buffer_drain.sv
// Store buffer drain: pops committed stores one at a time and issues each
// as a single aligned 32-bit write, holding it until the memory acknowledges.
// Optional write timeout is enabled by defining ST_DRAIN_TIMEOUT_EN.
module store_buffer_drain
   import data_memory_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                st_buf_empty_i,
   output logic                st_buf_pop_o,
   input  store_buffer_entry_t st_buf_packet_i,
   input  logic                drain_hold_i,
   output logic                mem_write_o,
   output logic [DATA_W-1:0]   mem_address_o,
   output logic [DATA_W-1:0]   mem_data_o,
   output logic [BE_W-1:0]     mem_byte_enable_o,
   input  logic                mem_ack_i,
   output logic                idle_o,
   output logic                misaligned_o,
   output logic                timeout_o
);

   // Elaboration-time sanity check on the timeout configuration.
   if (TIMEOUT_CYCLES < 1 || CNT_WIDTH < $clog2(TIMEOUT_CYCLES + 1)) begin : g_param_check
      $error("store_buffer_drain: TIMEOUT_CYCLES must be >= 1 and fit in CNT_WIDTH");
   end

   drain_state_t      state_q;
   logic              pop_q;
   logic              write_q;
   logic              idle_q;
   logic              misaligned_q;
   logic [DATA_W-1:0] address_q;
   logic [DATA_W-1:0] data_q;
   logic [BE_W-1:0]   byte_enable_q;

   logic              start_pop_d;
   logic [BE_W-1:0]   lane_be_d;
   logic [DATA_W-1:0] lane_data_d;
   logic              lane_misaligned_d;

   // A new pop may start only with an entry available and no hold request.
   assign start_pop_d = !st_buf_empty_i && !drain_hold_i;

   store_lane_aligner u_aligner (
      .addr_lsb_i   (st_buf_packet_i.address[1:0]),
      .width_i      (st_buf_packet_i.store_width),
      .data_i       (st_buf_packet_i.data),
      .be_o         (lane_be_d),
      .lane_data_o  (lane_data_d),
      .misaligned_o (lane_misaligned_d)
   );

`ifdef ST_DRAIN_TIMEOUT_EN
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 timeout_q;

   // Number of ack-less WRITE cycles including the current one.
   assign cnt_d     = cnt_q + CNT_WIDTH'(1);
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   // Drain sequencer with all bus-facing outputs registered.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // NOTE: the write payload registers are reset too, so the bus shows
         // zeros rather than stale data immediately after reset.
         state_q       <= IDLE;
         pop_q         <= 1'b0;
         write_q       <= 1'b0;
         idle_q        <= 1'b1;
         misaligned_q  <= 1'b0;
         address_q     <= '0;
         data_q        <= '0;
         byte_enable_q <= '0;
`ifdef ST_DRAIN_TIMEOUT_EN
         cnt_q         <= '0;
         timeout_q     <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees the
         // state as it was at the clock edge. Pulses default low each cycle.
         pop_q        <= 1'b0;
         misaligned_q <= 1'b0;
`ifdef ST_DRAIN_TIMEOUT_EN
         timeout_q    <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (start_pop_d) begin
                  state_q <= POP;
                  pop_q   <= 1'b1;
                  idle_q  <= 1'b0;
               end
            end
            POP: begin
               // The buffer presents the popped entry during the next cycle.
               state_q <= LATCH;
            end
            LATCH: begin
               if (lane_misaligned_d) begin
                  misaligned_q <= 1'b1;
                  state_q      <= IDLE;
                  idle_q       <= 1'b1;
               end else begin
                  address_q     <= word_align(st_buf_packet_i.address);
                  data_q        <= lane_data_d;
                  byte_enable_q <= lane_be_d;
                  write_q       <= 1'b1;
                  state_q       <= WRITE;
`ifdef ST_DRAIN_TIMEOUT_EN
                  cnt_q         <= '0;
`endif
               end
            end
            WRITE: begin
               if (mem_ack_i) begin
                  write_q <= 1'b0;
                  // Back-to-back pop keeps pops three cycles apart, so the
                  // buffer's registered empty flag has settled by now.
                  if (start_pop_d) begin
                     state_q <= POP;
                     pop_q   <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     idle_q  <= 1'b1;
                  end
               end
`ifdef ST_DRAIN_TIMEOUT_EN
               else if (cnt_d == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                  // Limit reached without ack: abandon the entry.
                  write_q   <= 1'b0;
                  timeout_q <= 1'b1;
                  state_q   <= IDLE;
                  idle_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
`endif
            end
            default: begin
               state_q <= IDLE;
               write_q <= 1'b0;
               idle_q  <= 1'b1;
            end
         endcase
      end
   end

   assign st_buf_pop_o      = pop_q;
   assign mem_write_o       = write_q;
   assign mem_address_o     = address_q;
   assign mem_data_o        = data_q;
   assign mem_byte_enable_o = byte_enable_q;
   assign idle_o            = idle_q;
   assign misaligned_o      = misaligned_q;

endmodule

// File: tb/tb_store_buffer_drain.sv
// Bench for store_buffer_drain: models the store buffer and the memory,
// keeps a transaction-level scoreboard of expected writes, and pins the
// model with hand-computed literals from directed scenarios.
`timescale 1ns/1ps
module tb_store_buffer_drain;
   import data_memory_pkg::*;

`ifdef ST_DRAIN_TIMEOUT_EN
   localparam int TIMEOUT_CYCLES = 4;
`else
   localparam int TIMEOUT_CYCLES = 255;
`endif

   logic                clk_i = 1'b0;
   logic                rst_n_i = 1'b0;
   logic                st_buf_empty_i = 1'b1;
   logic                st_buf_pop_o;
   store_buffer_entry_t st_buf_packet_i = '0;
   logic                drain_hold_i = 1'b0;
   logic                mem_write_o;
   logic [31:0]         mem_address_o;
   logic [31:0]         mem_data_o;
   logic [3:0]          mem_byte_enable_o;
   logic                mem_ack_i = 1'b0;
   logic                idle_o;
   logic                misaligned_o;
   logic                timeout_o;

   store_buffer_drain #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .st_buf_empty_i    (st_buf_empty_i),
      .st_buf_pop_o      (st_buf_pop_o),
      .st_buf_packet_i   (st_buf_packet_i),
      .drain_hold_i      (drain_hold_i),
      .mem_write_o       (mem_write_o),
      .mem_address_o     (mem_address_o),
      .mem_data_o        (mem_data_o),
      .mem_byte_enable_o (mem_byte_enable_o),
      .mem_ack_i         (mem_ack_i),
      .idle_o            (idle_o),
      .misaligned_o      (misaligned_o),
      .timeout_o         (timeout_o)
   );

   typedef struct {
      logic        mis;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      int          len;
      int          rise;
   } wr_t;

   store_buffer_entry_t sb_q[$];
   exp_t                exp_q[$];
   wr_t                 wr_log[$];
   int                  pop_log[$];
   wr_t                 cur_wr;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   ack_delay = 0;
   logic stray_ack = 1'b0;
   int   wcnt = 0;
   logic wr_prev = 1'b0;
   logic pop_prev = 1'b0;
   int   mis_cnt = 0;
   int   to_cnt = 0;

   int   c0, np0, np1, nw0, nm0, nt0, r0;
   logic done;

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected bus image of a store, from byte-lane arithmetic.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] d, input store_width_t w);
      exp_t e;
      int   nbytes;
      int   off;
      nbytes = (w == BYTE) ? 1 : (w == HALF) ? 2 : 4;
      off    = int'(a[1:0]);
      e.addr = a & 32'hFFFF_FFFC;
      e.mis  = (off % nbytes) != 0;
      for (int k = 0; k < 4; k++) begin
         e.be[k]         = (k >= off) && (k < off + nbytes);
         e.data[8*k +: 8] = d[8*(k % nbytes) +: 8];
      end
      return e;
   endfunction

   // Store buffer, memory responder and scoreboard, all evaluated mid-cycle.
   always @(negedge clk_i) begin
      if (!rst_n_i) begin
         wr_prev        = 1'b0;
         pop_prev       = 1'b0;
         wcnt           = 0;
         mem_ack_i      = 1'b0;
         st_buf_empty_i = (sb_q.size() == 0);
      end else begin
         // A write that ended last edge: acked, or dropped by timeout.
         if (wr_prev && !mem_write_o) begin
            cur_wr.len = wcnt;
            wr_log.push_back(cur_wr);
            if (!mem_ack_i) check("drop_needs_timeout", timeout_o, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else check("write_end_unexpected", 1, 0);
         end
         if (wr_prev && mem_ack_i) check("write_drop_after_ack", mem_write_o, 0);
         if (timeout_o) begin
            to_cnt++;
            check("timeout_cause", wr_prev && !mem_ack_i, 1);
         end
         if (mem_write_o) begin
            if (!wr_prev) begin
               cur_wr.addr = mem_address_o;
               cur_wr.data = mem_data_o;
               cur_wr.be   = mem_byte_enable_o;
               cur_wr.rise = cyc;
            end
            if (exp_q.size() == 0) begin
               check("write_unexpected", 1, 0);
            end else begin
               check("write_of_aligned", exp_q[0].mis, 0);
               check("write_addr", mem_address_o, exp_q[0].addr);
               check("write_data", mem_data_o, exp_q[0].data);
               check("write_be", mem_byte_enable_o, exp_q[0].be);
            end
         end
         if (misaligned_o) begin
            mis_cnt++;
            if (exp_q.size() == 0) begin
               check("misaligned_unexpected", 1, 0);
            end else begin
               check("misaligned_entry", exp_q[0].mis, 1);
               void'(exp_q.pop_front());
            end
         end
         if (st_buf_pop_o) check("pop_spacing", pop_prev, 0);
         if (st_buf_pop_o || mem_write_o) check("idle_while_busy", idle_o, 0);
         // Store buffer: the popped entry is presented for the following cycle.
         if (st_buf_pop_o) begin
            pop_log.push_back(cyc);
            if (sb_q.size() == 0) check("pop_when_empty", 1, 0);
            else st_buf_packet_i = sb_q.pop_front();
         end
         st_buf_empty_i = (sb_q.size() == 0);
         // Memory: ack after ack_delay write cycles; negative means never.
         if (mem_write_o) begin
            mem_ack_i = (ack_delay >= 0) && (wcnt == ack_delay);
            wcnt++;
         end else begin
            mem_ack_i = stray_ack;
            wcnt      = 0;
         end
         pop_prev = st_buf_pop_o;
         wr_prev  = mem_write_o;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #3;
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input store_width_t w);
      store_buffer_entry_t ent;
      ent.address     = a;
      ent.data        = d;
      ent.store_width = w;
      sb_q.push_back(ent);
      exp_q.push_back(model(a, d, w));
   endtask

   task automatic wait_idle(input string name, input int budget);
      done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         step(1);
         done = idle_o && !mem_write_o && (sb_q.size() == 0) && (exp_q.size() == 0);
      end
      check({name, "_drained"}, done, 1);
   endtask

   task automatic wait_rise(input string name, input int budget);
      done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         step(1);
         done = mem_write_o;
      end
      check({name, "_write_seen"}, done, 1);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_pop"}, st_buf_pop_o, 0);
      check({name, "_write"}, mem_write_o, 0);
      check({name, "_addr"}, mem_address_o, 0);
      check({name, "_data"}, mem_data_o, 0);
      check({name, "_be"}, mem_byte_enable_o, 0);
      check({name, "_idle"}, idle_o, 1);
      check({name, "_misaligned"}, misaligned_o, 0);
      check({name, "_timeout"}, timeout_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      step(3);
      check_reset_outputs("reset");
      rst_n_i = 1'b1;
      step(2);

      // WORD store, ack in the third write cycle.
      np0 = pop_log.size(); nw0 = wr_log.size(); ack_delay = 2; c0 = cyc;
      push(32'h0000_1008, 32'hDEAD_BEEF, WORD);
      wait_idle("t1", 40);
      check("t1_pops", pop_log.size() - np0, 1);
      check("t1_writes", wr_log.size() - nw0, 1);
      if (wr_log.size() > nw0 && pop_log.size() > np0) begin
         check("t1_addr", wr_log[nw0].addr, 32'h0000_1008);
         check("t1_be", wr_log[nw0].be, 4'b1111);
         check("t1_data", wr_log[nw0].data, 32'hDEAD_BEEF);
         check("t1_len", wr_log[nw0].len, 3);
         check("t1_pop_latency", pop_log[np0] - c0, 1);
         check("t1_write_latency", wr_log[nw0].rise - c0, 3);
      end
      check("t1_idle", idle_o, 1);

      // BYTE store in the top lane, zero-wait ack.
      nw0 = wr_log.size(); ack_delay = 0;
      push(32'h0000_0103, 32'h0000_00A5, BYTE);
      wait_idle("t2", 40);
      check("t2_writes", wr_log.size() - nw0, 1);
      if (wr_log.size() > nw0) begin
         check("t2_addr", wr_log[nw0].addr, 32'h0000_0100);
         check("t2_be", wr_log[nw0].be, 4'b1000);
         check("t2_data", wr_log[nw0].data, 32'hA5A5_A5A5);
         check("t2_len", wr_log[nw0].len, 1);
      end

      // Misaligned HALF and WORD dropped; aligned neighbours drain normally.
      nw0 = wr_log.size(); nm0 = mis_cnt;
      push(32'h0000_0101, 32'h0000_1234, HALF);
      push(32'h0000_2000, 32'h1122_3344, WORD);
      push(32'h0000_2002, 32'h0000_BEEF, HALF);
      push(32'h0000_2006, 32'h0000_0055, WORD);
      wait_idle("t3", 60);
      check("t3_misaligned_pulses", mis_cnt - nm0, 2);
      check("t3_writes", wr_log.size() - nw0, 2);
      if (wr_log.size() > nw0 + 1) begin
         check("t3_word_addr", wr_log[nw0].addr, 32'h0000_2000);
         check("t3_half_addr", wr_log[nw0+1].addr, 32'h0000_2000);
         check("t3_half_be", wr_log[nw0+1].be, 4'b1100);
         check("t3_half_data", wr_log[nw0+1].data, 32'hBEEF_BEEF);
      end

      // Three queued entries, zero-wait ack: one store every three cycles.
      np0 = pop_log.size(); nw0 = wr_log.size();
      push(32'h0000_3000, 32'h0102_0304, WORD);
      push(32'h0000_3005, 32'h0000_0077, BYTE);
      push(32'h0000_3006, 32'h0000_CAFE, HALF);
      wait_idle("t4", 60);
      check("t4_pops", pop_log.size() - np0, 3);
      check("t4_writes", wr_log.size() - nw0, 3);
      if (pop_log.size() > np0 + 2 && wr_log.size() > nw0 + 2) begin
         check("t4_pop_gap1", pop_log[np0+1] - pop_log[np0], 3);
         check("t4_pop_gap2", pop_log[np0+2] - pop_log[np0+1], 3);
         check("t4_write_gap", wr_log[nw0+2].rise - wr_log[nw0+1].rise, 3);
         check("t4_byte_be", wr_log[nw0+1].be, 4'b0010);
         check("t4_byte_data", wr_log[nw0+1].data, 32'h7777_7777);
         check("t4_half_data", wr_log[nw0+2].data, 32'hCAFE_CAFE);
      end
      check("t4_idle_after", idle_o, 1);

      // Hold raised during WRITE with two entries pending.
      nw0 = wr_log.size(); ack_delay = 3;
      push(32'h0000_4000, 32'hAAAA_0001, WORD);
      wait_rise("t5", 20);
      drain_hold_i = 1'b1;
      push(32'h0000_4004, 32'hAAAA_0002, WORD);
      push(32'h0000_4008, 32'hAAAA_0003, WORD);
      np1 = pop_log.size();
      step(12);
      check("t5_no_pop_under_hold", pop_log.size() - np1, 0);
      check("t5_write_done", mem_write_o, 0);
      check("t5_idle_under_hold", idle_o, 1);
      check("t5_first_write_done", wr_log.size() - nw0, 1);
      if (wr_log.size() > nw0) check("t5_first_len", wr_log[nw0].len, 4);
      r0 = cyc;
      drain_hold_i = 1'b0;
      wait_idle("t5", 60);
      check("t5_writes", wr_log.size() - nw0, 3);
      if (pop_log.size() > np1) check("t5_pop_after_release", pop_log[np1] - r0, 1);

      // Ack outside WRITE is ignored.
      np0 = pop_log.size(); nw0 = wr_log.size();
      stray_ack = 1'b1;
      step(4);
      check("t6_no_write", mem_write_o, 0);
      check("t6_idle", idle_o, 1);
      check("t6_no_pop", pop_log.size() - np0, 0);
      ack_delay = 1;
      push(32'h0000_5000, 32'h5555_0000, WORD);
      wait_idle("t6", 40);
      stray_ack = 1'b0;
      check("t6_writes", wr_log.size() - nw0, 1);
      if (wr_log.size() > nw0) check("t6_len", wr_log[nw0].len, 2);

`ifdef ST_DRAIN_TIMEOUT_EN
      // No ack: write aborted after four cycles, next entry proceeds.
      nw0 = wr_log.size(); nt0 = to_cnt; ack_delay = -1;
      push(32'h0000_6000, 32'h6666_0000, WORD);
      push(32'h0000_6004, 32'h6666_0004, WORD);
      done = 1'b0;
      for (int n = 0; n < 30 && !done; n++) begin
         step(1);
         done = (to_cnt != nt0);
      end
      check("t7_timeout_seen", done, 1);
      ack_delay = 0;
      wait_idle("t7", 40);
      check("t7_timeouts", to_cnt - nt0, 1);
      check("t7_writes", wr_log.size() - nw0, 2);
      if (wr_log.size() > nw0 + 1) begin
         check("t7_aborted_len", wr_log[nw0].len, 4);
         check("t7_next_addr", wr_log[nw0+1].addr, 32'h0000_6004);
      end
      // Ack arriving on the limit cycle counts as success.
      nw0 = wr_log.size(); nt0 = to_cnt; ack_delay = 3;
      push(32'h0000_6008, 32'h6666_0008, WORD);
      wait_idle("t7b", 40);
      check("t7b_no_timeout", to_cnt - nt0, 0);
      if (wr_log.size() > nw0) check("t7b_len", wr_log[nw0].len, 4);
`endif

      // Reset mid-WRITE clears outputs without a clock edge.
      ack_delay = -1;
      push(32'h0000_7000, 32'h7777_0000, WORD);
      wait_rise("t8", 20);
      rst_n_i = 1'b0;
      #1;
      check_reset_outputs("t8_async");
      sb_q.delete();
      exp_q.delete();
      step(2);
      rst_n_i = 1'b1;
      step(1);
      nw0 = wr_log.size(); ack_delay = 0;
      push(32'h0000_7011, 32'h0000_005A, BYTE);
      wait_idle("t8", 40);
      check("t8_writes", wr_log.size() - nw0, 1);
      if (wr_log.size() > nw0) begin
         check("t8_addr", wr_log[nw0].addr, 32'h0000_7010);
         check("t8_be", wr_log[nw0].be, 4'b0010);
         check("t8_data", wr_log[nw0].data, 32'h5A5A_5A5A);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
